booth_mult_param: RTL
=====================

BOOTH_MULT_PARAM -- requirements
Module: booth_mult_param

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be even and >= 4.
REQ-002 Port clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port resetn  input  1  asynchronous, active-low reset.
REQ-004 Port start  input  1  operation request; launch on rising edge only.
REQ-005 Port ack  input  1  host acknowledge of a completed result.
REQ-006 Port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned operands.
REQ-007 Port irq_enable  input  1  interrupt mask; 1 = irq permitted.
REQ-008 Port data_a  input  WIDTH  multiplicand.
REQ-009 Port data_b  input  WIDTH  multiplier.
REQ-010 Port busy  output  1  high from launch until ack accepted.
REQ-011 Port done  output  1  result valid, awaiting ack.
REQ-012 Port irq  output  1  interrupt request = done AND irq_enable, combinational.
REQ-013 Port result  output  2*WIDTH  product, held stable while done is high.

Function
REQ-014 States IDLE, CALC, DONE; reset state IDLE.
REQ-015 start_q register samples start every cycle; launch condition = state IDLE AND start AND NOT start_q.
REQ-016 On launch: data_a, data_b, signed_mode latched internally; iteration counter loaded with N; state -> CALC; busy -> 1.
REQ-017 N = WIDTH/2 when signed_mode = 1; N = WIDTH/2 + 1 when 0 (operands zero-extended by 2 bits).
REQ-018 CALC: one radix-4 Booth step per cycle; recode multiplier bits {b[2i+1], b[2i], b[2i-1]} (b[-1] = 0) into {0, +A, +2A, -A, -2A}; add to partial product, arithmetic-shift right by 2.
REQ-019 Booth partial products SHALL be formed at WIDTH+2 bits (WIDTH+3 in unsigned mode) so -2A of the most negative operand cannot overflow.
REQ-020 After N CALC cycles: result <= exact product truncated to 2*WIDTH bits, done -> 1, state -> DONE; done asserts exactly N+1 rising edges after the launch edge.
REQ-021 Input changes on data_a, data_b, signed_mode after launch SHALL NOT affect the current product.
REQ-022 start (level or new edge) in CALC or DONE ignored; start held high through DONE and ack SHALL NOT relaunch; a fresh low-to-high edge in IDLE is required.
REQ-023 ack in IDLE or CALC ignored; ack in DONE -> state IDLE, done 0, busy 0 on next edge; result retains last value.
REQ-024 irq_enable toggled while in DONE: irq follows immediately; done unaffected.
REQ-025 Launch edge and ack coincident cannot occur (exclusive states); ack and new start edge in same DONE cycle: ack accepted, start edge discarded.
REQ-026 Back-to-back: minimum spacing between launches = N+3 cycles (CALC, DONE, IDLE, start re-arm).

Reset
REQ-027 resetn low asynchronously forces: state IDLE, busy 0, done 0, irq 0, result 0, start_q 0, counter 0, internal operands 0.
REQ-028 Reset asserted mid-CALC or in DONE aborts the operation; no partial result visible after release.
REQ-029 After resetn release, start already high SHALL NOT launch until it goes low then high (start_q resets to 0 but launch requires start_q observed low; start_q SHALL reset to 1).
REQ-030 REQ-029 overrides REQ-027 for start_q: start_q reset value is 1.

Verification (WIDTH = 16 unless stated)
REQ-031 signed, 2 x 7, irq_enable 1 -> done and irq high 9 edges after launch, result 32'h0000000E; ack -> busy/done/irq 0 next edge.
REQ-032 signed, 89 x -7 and -180 x 29 -> 32'hFFFFFD91 and 32'hFFFFEB9C.
REQ-033 signed, 16'h7FFF x 16'h7FFF -> 32'h3FFF0001; 16'h8000 x 16'h8000 -> 32'h40000000.
REQ-034 unsigned, 16'hFFFF x 16'hFFFF -> 32'hFFFE0001, done 10 edges after launch; same operands signed -> 32'h00000001.
REQ-035 start held high across ack, irq_enable 0 -> irq stays 0, no relaunch; resetn pulsed mid-CALC -> all outputs 0 immediately, start must toggle to relaunch.
REQ-036 WIDTH = 8 instance, signed, -128 x -128 -> 16'h4000 after 5 edges; random signed/unsigned sweep vs. reference model, 1000 vectors, zero mismatches.

Source files
------------

// File: rtl/booth_mult_param.sv
// Sequential radix-4 Booth multiplier: one recoded multiplier digit per clock,
// launched on a start rising edge, result held under a done/ack handshake.
module booth_mult_param #(
  parameter int WIDTH = 16  // even, >= 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               ack,
  input  logic               signed_mode,
  input  logic               irq_enable,
  input  logic [WIDTH-1:0]   data_a,
  input  logic [WIDTH-1:0]   data_b,
  output logic               busy,
  output logic               done,
  output logic               irq,
  output logic [2*WIDTH-1:0] result
);

  localparam int EW = WIDTH + 2;  // operands extended by two bits (sign or zero)
  localparam int PW = WIDTH + 3;  // partial product wide enough for -2A of the most negative operand
  localparam int LW = WIDTH + 3;  // extended multiplier plus the implicit b[-1] bit
  localparam int CW = $clog2(WIDTH / 2 + 2);

  localparam logic [CW-1:0] N_SIGNED   = CW'(WIDTH / 2);
  localparam logic [CW-1:0] N_UNSIGNED = CW'(WIDTH / 2 + 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           r_state;
  logic                 r_start_q;
  logic                 r_mode;
  logic                 r_busy;
  logic                 r_done;
  logic [CW-1:0]        r_cnt;
  logic [EW-1:0]        r_a;
  logic signed [PW-1:0] r_hi;
  logic [LW-1:0]        r_lo;
  logic [2*WIDTH-1:0]   r_result;

  logic                 w_launch;
  logic [EW-1:0]        w_a_ext;
  logic [EW-1:0]        w_b_ext;
  logic signed [PW-1:0] w_pp;
  logic [2*WIDTH-1:0]   w_product;

  function automatic logic signed [PW-1:0] booth_term(input logic [2:0] trip,
                                                      input logic [EW-1:0] a);
    logic signed [PW-1:0] a1;
    logic signed [PW-1:0] a2;
    a1 = {a[EW-1], a};
    a2 = {a, 1'b0};
    case (trip)
      3'b001, 3'b010: booth_term = a1;
      3'b011:         booth_term = a2;
      3'b100:         booth_term = -a2;
      3'b101, 3'b110: booth_term = -a1;
      default:        booth_term = '0;
    endcase
  endfunction

  // Launch detect, operand extension, Booth step and final product alignment
  always_comb begin
    w_launch = (r_state == S_IDLE) && start && !r_start_q;
    if (signed_mode) begin
      w_a_ext = {{2{data_a[WIDTH-1]}}, data_a};
      w_b_ext = {{2{data_b[WIDTH-1]}}, data_b};
    end else begin
      w_a_ext = {2'b00, data_a};
      w_b_ext = {2'b00, data_b};
    end
    w_pp = r_hi + booth_term(r_lo[2:0], r_a);
    // Signed mode retires WIDTH multiplier bits, unsigned mode WIDTH+2, so the product sits at a different offset
    if (r_mode) begin
      w_product = {r_hi[WIDTH-1:0], r_lo[LW-1:3]};
    end else begin
      w_product = {r_hi[WIDTH-3:0], r_lo[LW-1:1]};
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b1;
      r_mode    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= '0;
      r_a       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_result  <= '0;
    end else begin
      r_start_q <= start;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_a     <= w_a_ext;
            r_hi    <= '0;
            r_lo    <= {w_b_ext, 1'b0};
            r_mode  <= signed_mode;
            r_cnt   <= signed_mode ? N_SIGNED : N_UNSIGNED;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (r_cnt != '0) begin
            r_hi  <= {{2{w_pp[PW-1]}}, w_pp[PW-1:2]};
            r_lo  <= {w_pp[1:0], r_lo[LW-1:2]};
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            r_result <= w_product;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (ack) begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign irq    = r_done & irq_enable;

endmodule
